// File: rtl/spi_console_sink.sv
// Oversampling SPI console receiver: deserialises MOSI words into a FIFO with a ready/valid output stream.
// Latency: last SCLK rise -> out_valid high after the 3rd clk edge (observable the following cycle).
// Backpressure: out_ready low lets the FIFO fill; words arriving while full are dropped and counted.
module spi_console_sink #(
    parameter int                WORD_W     = 8,
    parameter int                MSB_FIRST  = 1,
    parameter int                FIFO_DEPTH = 16,
    parameter int                USE_CS     = 1,
    parameter int                EOT_EN     = 1,
    parameter logic [WORD_W-1:0] EOT_WORD   = WORD_W'(4)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          spi_sclk,
    input  logic                          spi_mosi,
    input  logic                          spi_cs_n,
    input  logic                          clr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_W-1:0]             out_data,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ovf,
    output logic                          frame_err,
    output logic                          eot,
    output logic [15:0]                   drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(WORD_W + 1);

    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic sclk_m, sclk_s, sclk_d;
    logic mosi_m, mosi_s;
    logic cs_m, cs_s;

    // Two-flop synchronisers for the async SPI pins, plus a delayed SCLK for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_m <= 1'b0;
            sclk_s <= 1'b0;
            sclk_d <= 1'b0;
            mosi_m <= 1'b0;
            mosi_s <= 1'b0;
            cs_m   <= 1'b1;
            cs_s   <= 1'b1;
        end else begin
            sclk_m <= spi_sclk;
            sclk_s <= sclk_m;
            sclk_d <= sclk_s;
            mosi_m <= spi_mosi;
            mosi_s <= mosi_m;
            cs_m   <= spi_cs_n;
            cs_s   <= cs_m;
        end
    end

    // ------------------------------------------------------------------
    // Deserialiser
    // ------------------------------------------------------------------
    logic              frame_active;
    logic              cs_idle;
    logic              sample;
    logic              word_done;
    logic              frame_abort;
    logic [CW-1:0]     bit_cnt;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] shift_next;

    // With USE_CS=0 the frame is permanently open and CS never idles the shifter.
    assign cs_idle      = (USE_CS != 0) && cs_s;
    assign frame_active = !cs_idle;
    assign sample       = sclk_s && !sclk_d && frame_active;
    assign word_done    = sample && (bit_cnt == LAST_BIT);
    // bit_cnt is forced to 0 while CS is idle, so this fires exactly once per aborted word.
    assign frame_abort  = cs_idle && (bit_cnt != '0);

    // Shift register value including the bit sampled this cycle.
    always_comb begin
        shift_next = shift_q;
        if (MSB_FIRST != 0) begin
            shift_next = {shift_q[WORD_W-2:0], mosi_s};
        end else begin
            shift_next = {mosi_s, shift_q[WORD_W-1:1]};
        end
    end

    // Shift in one bit per SCLK rise; the counter wraps when a word completes or CS idles.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            shift_q <= '0;
        end else if (cs_idle) begin
            bit_cnt <= '0;
        end else if (sample) begin
            shift_q <= shift_next;
            bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Word disposal
    // ------------------------------------------------------------------
    logic is_eot;
    logic pop;
    logic full;
    logic push;
    logic drop;

    assign pop    = out_valid && out_ready;
    assign full   = (level == FULL_LVL);
    assign is_eot = word_done && (EOT_EN != 0) && (shift_next == EOT_WORD);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept the word.
    assign push   = word_done && !is_eot && (!full || pop);
    assign drop   = word_done && !is_eot && full && !pop;

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Storage array; contents need no reset because out_data is gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shift_next;
        end
    end

    // Pointers wrap naturally at FIFO_DEPTH; level alone tells full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign out_valid = (level != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // ------------------------------------------------------------------
    // Status flags
    // ------------------------------------------------------------------
    // Sticky flags: a set event in the same cycle as clr takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf       <= 1'b0;
            frame_err <= 1'b0;
            eot       <= 1'b0;
        end else begin
            if (drop) begin
                ovf <= 1'b1;
            end else if (clr) begin
                ovf <= 1'b0;
            end
            if (frame_abort) begin
                frame_err <= 1'b1;
            end else if (clr) begin
                frame_err <= 1'b0;
            end
            if (is_eot) begin
                eot <= 1'b1;
            end else if (clr) begin
                eot <= 1'b0;
            end
        end
    end

    // Saturating drop counter; a drop coinciding with clr restarts the count at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop) begin
            if (clr) begin
                drop_cnt <= 16'd1;
            end else if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end else if (clr) begin
            drop_cnt <= '0;
        end
    end

endmodule
